// File: rtl/serdes_pkg.sv
// Shared definitions for the parallel-to-serial feeder: default word size,
// FSM state type and the bit counter width helper.
package serdes_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // Bit counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/word_hold_buf.sv
// One-entry word buffer between the upstream valid/ready source and the shifter.
// The shifter pops it when it copies the word into its shift register.
module word_hold_buf
  import serdes_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:WIDTH-1] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             pop,
  output logic             full,
  output logic [0:WIDTH-1] out_data
);

  logic             full_q, full_d;
  logic [0:WIDTH-1] data_q, data_d;
  logic             accept;

  assign in_ready = !full_q;
  assign accept   = in_valid && in_ready;
  assign full     = full_q;
  assign out_data = data_q;

  // Pop empties the slot; a simultaneous accept wins and leaves it full with the new word.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (pop) begin
      full_d = 1'b0;
    end
    if (accept) begin
      full_d = 1'b1;
      data_d = in_data;
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out feeder for a downstream SIPO. Word bit WIDTH-1 goes out
// first so that it ends up deepest in the SIPO (q[WIDTH-1]); word_done marks the
// cycle in which the SIPO holds the whole word.
module piso_serializer
  import serdes_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:WIDTH-1] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             pause,
  output logic             sout,
  output logic             sout_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int              CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  ser_state_t       state_q, state_d;
  logic [0:WIDTH-1] shreg_q, shreg_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             last_q, last_d;       // the bit now on sout is the word's last one
  logic             word_done_q, word_done_d;

  logic             hold_full;
  logic [0:WIDTH-1] hold_data;
  logic             load;
  logic             cur_bit;

  word_hold_buf #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .in_data  (s_data),
    .in_valid (s_valid),
    .in_ready (s_ready),
    .pop      (load),
    .full     (hold_full),
    .out_data (hold_data)
  );

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign word_done  = word_done_q;
  assign busy       = (state_q != IDLE) || hold_full;

  // Select shreg[WIDTH-1-bit_cnt]: the counter walks from the top word bit down to bit 0.
  always_comb begin
    cur_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (bit_cnt_q == CNT_W'(WIDTH - 1 - i)) begin
        cur_bit = shreg_q[i];
      end
    end
  end

  // FSM next state: load from the hold buffer, shift one bit per cycle, reload without a bubble.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    sout_d       = sout_q;
    sout_valid_d = sout_valid_q;
    last_d       = last_q;
    word_done_d  = 1'b0;
    load         = 1'b0;
    if (pause) begin
      // Freeze sout, counter and state; nothing counts as a live bit while frozen.
      sout_valid_d = 1'b0;
      last_d       = 1'b0;
    end else begin
      // The SIPO captures the last bit on this edge, so it holds the word next cycle.
      word_done_d = last_q;
      case (state_q)
        IDLE: begin
          sout_d       = 1'b0;
          sout_valid_d = 1'b0;
          last_d       = 1'b0;
          if (hold_full) begin
            load      = 1'b1;
            shreg_d   = hold_data;
            bit_cnt_d = '0;
            state_d   = SHIFT;
          end
        end
        SHIFT: begin
          sout_d       = cur_bit;
          sout_valid_d = 1'b1;
          last_d       = (bit_cnt_q == LAST_CNT);
          bit_cnt_d    = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_CNT) begin
            bit_cnt_d = '0;
            if (hold_full) begin
              load    = 1'b1;
              shreg_d = hold_data;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      last_q       <= 1'b0;
      word_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      last_q       <= last_d;
      word_done_q  <= word_done_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer (WIDTH=4) driving a model SIPO. A background monitor
// predicts the serial stream and word_done timing from accepted words.
module tb_piso_serializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [0:W-1] s_data = '0;
  logic         s_valid = 1'b0;
  logic         pause = 1'b0;
  logic         s_ready, sout, sout_valid, word_done, busy;
  logic [0:W-1] q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .pause      (pause),
    .sout       (sout),
    .sout_valid (sout_valid),
    .word_done  (word_done),
    .busy       (busy)
  );

  // Downstream SIPO: q[0] takes din, older bits move towards q[W-1].
  always_ff @(posedge clk) q <= {sout, q[0:W-2]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [0:W-1] acc_q[$];
  logic         bit_q[$];
  int           bits_seen = 0;
  logic         done_exp = 1'b0;
  logic         exp_bit;
  logic [0:W-1] exp_word;

  always @(posedge clk) begin
    if (rst) begin
      acc_q.delete();
      bit_q.delete();
      bits_seen = 0;
      done_exp  = 1'b0;
    end else begin
      chk("word_done_timing", word_done, done_exp);
      if (done_exp) begin
        exp_word = 'x;
        if (acc_q.size() != 0) exp_word = acc_q.pop_front();
        chk("sipo_q", q, exp_word);
      end
      done_exp = 1'b0;
      if (sout_valid) begin
        exp_bit = 1'bx;
        if (bit_q.size() != 0) exp_bit = bit_q.pop_front();
        chk("sout_bit", sout, exp_bit);
        bits_seen++;
        if (bits_seen == W) begin
          bits_seen = 0;
          done_exp  = 1'b1;
        end
      end
      if (s_valid && s_ready) begin
        acc_q.push_back(s_data);
        for (int k = W - 1; k >= 0; k--) bit_q.push_back(s_data[k]);
      end
    end
  end

  // Offer a word and hold it until accepted; returns in the cycle after the accept edge.
  task automatic send(input logic [0:W-1] d);
    int n;
    n = 0;
    s_data  = d;
    s_valid = 1'b1;
    while (!s_ready && n < 50) begin
      tick();
      n++;
    end
    chk("send_accept_in_time", (n < 50), 1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((acc_q.size() != 0 || busy) && n < 100) begin
      tick();
      n++;
    end
    chk("drain_in_time", (n < 100), 1);
    tick();
  endtask

  // Exact-latency check of one isolated word.
  task automatic run_vec(input logic [0:W-1] d, input logic [0:W-1] seq);
    send(d);                               // cycle t
    tick();                                // t+1
    chk("lat_no_bit_yet", sout_valid, 0);
    for (int k = 0; k < W; k++) begin      // t+2 .. t+5
      tick();
      chk("lat_sout", sout, seq[k]);
      chk("lat_sout_valid", sout_valid, 1);
      chk("lat_done_early", word_done, 0);
    end
    tick();                                // t+6
    chk("lat_word_done", word_done, 1);
    chk("lat_sipo_q", q, d);
    tick();
    chk("lat_done_pulse", word_done, 0);
    chk("lat_idle_valid", sout_valid, 0);
  endtask

  typedef struct {
    logic [0:W-1] data;
    logic [0:W-1] seq;   // seq[k] = k-th bit expected on sout
  } vec_t;

  vec_t tbl[6];

  int run_len, rises, d1, d2, cyc, n_c, gap;
  logic prev_v, saw_done;

  initial begin
    tbl[0] = '{data: 4'b1011, seq: 4'b1101};
    tbl[1] = '{data: 4'b0110, seq: 4'b0110};
    tbl[2] = '{data: 4'b1001, seq: 4'b1001};
    tbl[3] = '{data: 4'b1000, seq: 4'b0001};
    tbl[4] = '{data: 4'b0001, seq: 4'b1000};
    tbl[5] = '{data: 4'b1110, seq: 4'b0111};

    // 1: reset values
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_sout", sout, 0);
    chk("rst_sout_valid", sout_valid, 0);
    chk("rst_word_done", word_done, 0);
    chk("rst_busy", busy, 0);
    tick();

    // 2: single words with exact latency
    for (int i = 0; i < 6; i++) begin
      run_vec(tbl[i].data, tbl[i].seq);
      drain();
    end

    // 3: back-to-back words
    run_len = 0; rises = 0; d1 = -1; d2 = -1; cyc = 0; prev_v = 1'b0;
    fork
      begin
        send(4'b0110);
        send(4'b1001);
      end
      begin
        repeat (20) begin
          tick();
          cyc++;
          if (sout_valid) run_len++;
          if (sout_valid && !prev_v) rises++;
          prev_v = sout_valid;
          if (word_done) begin
            if (d1 < 0) d1 = cyc;
            else if (d2 < 0) d2 = cyc;
          end
        end
      end
    join
    chk("b2b_valid_count", run_len, 8);
    chk("b2b_valid_runs", rises, 1);
    chk("b2b_done_spacing", d2 - d1, 4);
    drain();

    // 4: backpressure on a third word
    send(4'b0110);
    send(4'b1001);
    s_data  = 4'b1111;
    s_valid = 1'b1;
    chk("bp_ready_low", s_ready, 0);
    n_c = 0;
    while (!s_ready && n_c < 50) begin
      tick();
      n_c++;
    end
    chk("bp_wait_cycles", n_c, 3);
    chk("bp_still_shifting", sout_valid, 1);
    tick();
    s_valid = 1'b0;
    drain();

    // 5: pause while idle with hold full
    pause = 1'b1;
    send(4'b0101);
    repeat (4) begin
      tick();
      chk("pause_no_valid", sout_valid, 0);
      chk("pause_no_load", s_ready, 0);
      chk("pause_busy", busy, 1);
    end
    pause = 1'b0;
    tick();
    chk("unpause_load_cycle", sout_valid, 0);
    tick();
    chk("unpause_first_valid", sout_valid, 1);
    chk("unpause_first_bit", sout, 1);
    saw_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (word_done) saw_done = 1'b1;
    end
    chk("unpause_word_done", saw_done, 1);
    drain();

    // 6: reset mid-word
    send(4'b1100);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("midrst_sout", sout, 0);
    chk("midrst_sout_valid", sout_valid, 0);
    chk("midrst_word_done", word_done, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_s_ready", s_ready, 1);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (8) begin
      tick();
      if (word_done) saw_done = 1'b1;
    end
    chk("midrst_no_done", saw_done, 0);
    run_vec(4'b0011, 4'b1100);
    drain();

    // Randomized traffic against the model
    for (int i = 0; i < 200; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
      send(W'($urandom));
    end
    drain();
    chk("model_words_empty", acc_q.size(), 0);
    chk("model_bits_empty", bit_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
